// File: rtl/time_disp_scan.sv
// rtl/time_disp_scan.sv - six-digit multiplexed seven-segment scan driver
// Frame-coherent snapshot, anti-ghost blanking, leading-zero suppression, set-mode blink.
module time_disp_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int BLINK_DIV = 25000000,
    parameter int HIDE_LZ   = 1
) (
    input  logic       clk,
    input  logic       sys_rst_p,
    input  logic       set_time,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    output logic [7:0] seg,
    output logic [5:0] dig_n
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [BW-1:0] bcnt;
    logic          blink_on;
    logic          set_q;
    logic [23:0]   snap;

    logic          frame_start;
    logic          slot_end;
    logic [23:0]   snap_eff;
    logic          set_rise;
    logic [BW-1:0] bcnt_eff;
    logic          blink_eff;
    logic          bcnt_wrap;
    logic [3:0]    nib;
    logic          dp_on;
    logic          blank_lz;
    logic          blank_blink;
    logic [7:0]    seg_next;
    logic [5:0]    dig_next;

    function automatic logic [6:0] encode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h40;
        endcase
        return r;
    endfunction

    // The frame-start cycle uses the live inputs so the displayed value
    // always matches the snapshot being taken in that same cycle.
    always_comb begin
        frame_start = (pcnt == '0) && (idx == 3'd0);
        slot_end    = (pcnt == PW'(SCAN_DIV - 1));
        snap_eff    = frame_start ? {hour, min, sec} : snap;
        set_rise    = set_time & ~set_q;
        bcnt_eff    = set_rise ? '0 : bcnt;
        blink_eff   = set_rise | blink_on;
        bcnt_wrap   = (bcnt_eff == BW'(BLINK_DIV - 1));
    end

    always_comb begin
        nib = 4'd0;
        case (idx)
            3'd0:    nib = snap_eff[3:0];
            3'd1:    nib = snap_eff[7:4];
            3'd2:    nib = snap_eff[11:8];
            3'd3:    nib = snap_eff[15:12];
            3'd4:    nib = snap_eff[19:16];
            3'd5:    nib = snap_eff[23:20];
            default: nib = 4'd0;
        endcase
    end

    always_comb begin
        dp_on       = (idx == 3'd2) || (idx == 3'd4);
        blank_lz    = (HIDE_LZ != 0) && (idx == 3'd5) && (nib == 4'd0);
        blank_blink = set_time && !blink_eff && (idx >= 3'd2);
        seg_next    = 8'hFF;
        dig_next    = 6'h3F;
        if (int'(pcnt) >= BLANK_CYC) begin
            case (idx)
                3'd0:    dig_next = 6'h3E;
                3'd1:    dig_next = 6'h3D;
                3'd2:    dig_next = 6'h3B;
                3'd3:    dig_next = 6'h37;
                3'd4:    dig_next = 6'h2F;
                3'd5:    dig_next = 6'h1F;
                default: dig_next = 6'h3F;
            endcase
            if (!blank_lz && !blank_blink) begin
                seg_next = ~{dp_on, encode(nib)};
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            pcnt     <= '0;
            idx      <= 3'd0;
            snap     <= 24'h0;
            bcnt     <= '0;
            blink_on <= 1'b1;
            set_q    <= 1'b0;
            seg      <= 8'hFF;
            dig_n    <= 6'h3F;
        end else begin
            set_q <= set_time;
            snap  <= snap_eff;
            seg   <= seg_next;
            dig_n <= dig_next;
            if (slot_end) begin
                pcnt <= '0;
                idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            // A set_time rise restarts the blink phase; it overrides a coincident wrap.
            if (bcnt_wrap) begin
                bcnt     <= '0;
                blink_on <= ~blink_eff;
            end else begin
                bcnt     <= bcnt_eff + 1'b1;
                blink_on <= blink_eff;
            end
        end
    end

endmodule

// File: tb/tb_time_disp_scan.sv
// tb/tb_time_disp_scan.sv - directed scoreboard bench for time_disp_scan
// Cycle numbers count rising edges since reset release, sampled 1 time unit after the edge.
module tb_time_disp_scan;

    logic       clk;
    logic       rst;
    logic       set_time;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] seg;
    logic [5:0] dig_n;

    typedef struct {
        string      tag;
        logic [5:0] d;
        logic [7:0] s;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    time_disp_scan #(
        .SCAN_DIV (8),
        .BLANK_CYC(2),
        .BLINK_DIV(40),
        .HIDE_LZ  (1)
    ) dut (
        .clk      (clk),
        .sys_rst_p(rst),
        .set_time (set_time),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .seg      (seg),
        .dig_n    (dig_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        if (n < cyc) begin
            n_cmp++;
            n_err++;
            $error("FAIL goto target %0d got cycle %0d", n, cyc);
        end
        while (cyc < n) tick();
    endtask

    task automatic push_exp(input string tag, input logic [5:0] d, input logic [7:0] s);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.s   = s;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (dig_n === e.d && seg === e.s)
        else begin
            n_err++;
            $error("FAIL %s cyc %0d dig_n=%h seg=%h expected dig_n=%h seg=%h",
                   e.tag, cyc, dig_n, seg, e.d, e.s);
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] d, input logic [7:0] s);
        push_exp(tag, d, s);
        pop_cmp();
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        rst = 1'b1; set_time = 1'b0;
        hour = 8'h09; min = 8'h45; sec = 8'h37;
        tick();
        chk("rst_hold", 6'h3F, 8'hFF);
        tick();
        rst = 1'b0;
        cyc = 0;

        goto(1);   chk("rel_c1",   6'h3F, 8'hFF);
        goto(2);   chk("rel_c2",   6'h3F, 8'hFF);
        goto(3);   chk("idx0_c3",  6'h3E, 8'hF8);
        goto(8);   chk("idx0_c8",  6'h3E, 8'hF8);
        goto(9);   chk("ghost_c9", 6'h3F, 8'hFF);
        goto(11);  chk("idx1",     6'h3D, 8'hB0);
        goto(19);  chk("idx2_dp",  6'h3B, 8'h12);
        goto(27);  chk("idx3",     6'h37, 8'h99);
        sec = 8'h38;
        goto(35);  chk("idx4_dp",  6'h2F, 8'h10);
        goto(43);  chk("idx5_lz",  6'h1F, 8'hFF);
        goto(51);  chk("tear_f1",  6'h3E, 8'h80);
        goto(59);  chk("tear_f1b", 6'h3D, 8'hB0);

        sec = 8'h3C; hour = 8'h20;
        goto(99);  chk("dash",     6'h3E, 8'hBF);
        goto(131); chk("h_units0", 6'h2F, 8'h40);
        goto(139); chk("h_tens2",  6'h1F, 8'hA4);

        hour = 8'h12; min = 8'h34; sec = 8'h56;
        goto(150); chk("pre_set",  6'h3E, 8'h82);
        set_time = 1'b1;
        goto(155); chk("bon_idx1", 6'h3D, 8'h92);
        goto(163); chk("bon_idx2", 6'h3B, 8'h19);
        goto(171); chk("bon_idx3", 6'h37, 8'hB0);
        goto(179); chk("bon_idx4", 6'h2F, 8'h24);
        goto(187); chk("bon_idx5", 6'h1F, 8'hF9);
        goto(190); chk("bon_last", 6'h1F, 8'hF9);
        goto(191); chk("boff_1st", 6'h1F, 8'hFF);
        goto(195); chk("boff_s0",  6'h3E, 8'h82);
        goto(203); chk("boff_s1",  6'h3D, 8'h92);
        goto(211); chk("boff_m0",  6'h3B, 8'hFF);

        goto(216); set_time = 1'b0;
        goto(217); set_time = 1'b1;
        goto(218); chk("rr_ghost", 6'h3F, 8'hFF);
        goto(219); chk("rr_vis",   6'h37, 8'hB0);
        goto(227); chk("rr_idx4",  6'h2F, 8'h24);
        goto(235); chk("rr_idx5",  6'h1F, 8'hF9);
        goto(259); chk("rr_off2",  6'h3B, 8'hFF);
        goto(267); chk("rr_off3",  6'h37, 8'hFF);
        goto(270); set_time = 1'b0;

        goto(300); hour = 8'h07; min = 8'h08; sec = 8'h19;
        goto(325); chk("pre_rst",  6'h2F, 8'h24);
        rst = 1'b1;
        #1;
        chk("rst_async", 6'h3F, 8'hFF);
        tick();
        chk("rst_held",  6'h3F, 8'hFF);
        rst = 1'b0;
        cyc = 0;
        goto(2);   chk("rs_c2",    6'h3F, 8'hFF);
        goto(3);   chk("rs_idx0",  6'h3E, 8'h90);
        goto(35);  chk("rs_idx4",  6'h2F, 8'h78);
        goto(43);  chk("rs_idx5",  6'h1F, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_disp_scan.md
# time_disp_scan

Multiplexed six-digit seven-segment scan driver for the digital clock. It consumes the packed-BCD `hour`/`min`/`sec` buses and the `set_time` mode flag that the time-keeping counters use. It drives one shared segment bus plus six active-low digit enables, with anti-ghost blanking, frame-coherent input snapshots, leading-zero suppression and blinking of the hour/minute digits in set mode.

## Interface
- `SCAN_DIV`, 50000: clock cycles each digit slot lasts; legal range ≥ 2.
- `BLANK_CYC`, 2: cycles at the start of each slot with all digits off; legal range 0 ≤ BLANK_CYC < SCAN_DIV.
- `BLINK_DIV`, 25000000: clock cycles per blink half-period in set mode; legal range ≥ 1.
- `HIDE_LZ`, 1: when 1, the hour tens digit is blanked if it is 0.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `sys_rst_p`  in  1: reset, asynchronous, active-high.
- `set_time`  in  1: set mode flag, same clock domain.
- `hour`  in  8: BCD, upper nibble is tens, lower nibble is units.
- `min`  in  8: BCD, same packing as `hour`.
- `sec`  in  8: BCD, same packing as `hour`.
- `seg`  out  8: active-low segments. `seg[0..6]` = a..g, `seg[7]` = dp.
- `dig_n`  out  6: active-low digit enables. Index 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens, 4 = hour units, 5 = hour tens.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. When `pcnt` = SCAN_DIV-1, the digit index `idx` advances 0→1→…→5→0.
- Snapshot: when `pcnt`=0 and `idx`=0, the full `{hour,min,sec}` is latched. This includes the first cycle after reset release. Input changes at any other time have no effect until the next frame.
- Digit value: the snapshot nibble selected by `idx`.
- Segment encoding (active-high form gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble 10..15 encodes as dash 40 (segment g only).
- Decimal point: lit on idx 2 and 4 as separators, off on all other digits.
- Digit blanked (`seg`=FF, enable still asserted) when either of these holds:
  - `HIDE_LZ`=1, idx=5 and the nibble is 0.
  - `set_time`=1, `blink_on`=0 and idx ∈ {2,3,4,5}. The dp is also blanked in this case.
- Seconds digits are never blink-blanked.
- Anti-ghost: while `pcnt` < BLANK_CYC, `dig_n`=3F and `seg`=FF.
- Otherwise, `dig_n` has only bit `idx` low.
- Blink counter `bcnt` runs 0..BLINK_DIV-1 and toggles `blink_on` on wrap. It is free-running whenever not cleared.
- A rising edge of `set_time` (detected against a registered copy) clears `bcnt` to 0 and forces `blink_on`=1 in the same cycle. Entering set mode therefore always starts with digits visible.
- Simultaneous set_time rise and `bcnt` wrap: the clear wins, giving `blink_on`=1.

## Timing
- Reset values (asynchronous, immediate):
  - Outputs: `dig_n`=6'h3F, `seg`=8'hFF.
  - Internal state: `pcnt`=0, `idx`=0, `bcnt`=0, `blink_on`=1, snapshot=0, registered `set_time`=0.
- `seg` and `dig_n` are registered. The outputs in cycle n+1 reflect the `pcnt`/`idx`/snapshot/`blink_on` values of cycle n.
- Consequence: in the first cycle after reset release the outputs are still off.
  - Digit 0 is enabled during cycles BLANK_CYC+1 … SCAN_DIV after release.
  - The enable shows the snapshot taken in cycle 0.
- Frame length is 6×SCAN_DIV cycles.
- Per slot, each digit is enabled for SCAN_DIV−BLANK_CYC cycles.
- Reset asserted mid-frame: outputs go off at once. On release the scan restarts at idx 0 with a fresh snapshot.
- Blink phase length is exactly BLINK_DIV cycles.
- Blink changes take effect at the next output register update, with no frame alignment.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=40, HIDE_LZ=1.

- Reset: assert `sys_rst_p` → `dig_n`=3F and `seg`=FF immediately. After release, `dig_n` first reads 3E on cycle 3 and remains 3E through cycle 8.
- Static decode: hour=09, min=45, sec=37, set_time=0 → one frame shows:
  - idx0: `dig_n`=3E, `seg`=F8.
  - idx1: `dig_n`=3D, `seg`=B0.
  - idx2: `dig_n`=3B, `seg`=12.
  - idx3: `dig_n`=37, `seg`=99.
  - idx4: `dig_n`=2F, `seg`=10.
  - idx5: `dig_n`=1F, `seg`=FF (leading zero suppressed).
- Tearing: change sec from 37 to 38 while idx=3 → the current frame still shows F8 at idx0 on later slots. The next frame shows idx0 `seg`=80.
- Set-mode blink: raise set_time with hour=12, min=34 →
  - During the first 40 cycles, idx2 shows `seg`=19 (4 with dp) and idx5 shows `seg`=F9.
  - During the next 40 cycles, idx2..5 show `seg`=FF with `dig_n` still cycling.
  - idx0/1 show `seg` ≠ FF throughout.
  - Re-raising set_time mid off-phase restores visibility on the next cycle.
- Invalid BCD: sec=3C → idx0 `seg`=BF (dash). hour=20 → idx5 `seg`=A4 (not blanked).
- Reset mid-frame: assert reset at idx=4, pcnt=5 → outputs 3F/FF the same cycle. After release the sequence restarts at idx0, with the snapshot taken from the current inputs.
